// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the register-specified shift sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11} sh_t;
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;

    // Saturation points: one past the word width flushes the carry out for logical shifts.
    localparam logic [7:0] LSL_SAT = 8'd33;
    localparam logic [7:0] ASR_SAT = 8'd32;

    function automatic logic [5:0] clamp_amt(input logic [7:0] amt, input logic [7:0] sat);
        return (amt > sat) ? sat[5:0] : amt[5:0];
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single bounded shift step: shifts value by k positions with ARM carry semantics.
module shift_step
    import shift_ctrl_pkg::*;
(
    input  logic [31:0] value_i,
    input  sh_t         sh_i,
    input  logic [4:0]  k_i,
    input  logic        carry_i,
    output logic [31:0] value_o,
    output logic        carry_o
);

    logic        [63:0] lext;
    logic        [63:0] rext;
    logic signed [63:0] aext;
    logic        [31:0] rot;

    // Widened shifts leave the last bit shifted out at the seam (bit 32 or bit 31).
    always_comb begin
        lext = {32'b0, value_i} << k_i;
        rext = {value_i, 32'b0} >> k_i;
        aext = $signed({value_i, 32'b0}) >>> k_i;
        rot  = (value_i >> k_i) | (value_i << (6'd32 - {1'b0, k_i}));
        value_o = value_i;
        carry_o = carry_i;
        if (k_i != 5'd0) begin
            case (sh_i)
                LSL: begin value_o = lext[31:0];  carry_o = lext[32]; end
                LSR: begin value_o = rext[63:32]; carry_o = rext[31]; end
                ASR: begin value_o = aext[63:32]; carry_o = aext[31]; end
                default: begin value_o = rot;     carry_o = rot[31];  end
            endcase
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Multi-cycle sequencer for register-specified shifts, at most STEP bits per cycle.
// Define SHIFT_CTRL_RRX_EN to make ROR with a zero amount perform RRX.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned STEP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [1:0]  sh,
    input  logic [7:0]  amt,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic        cy_q, cy_d;
    logic [5:0]  rem_q, rem_d;
    sh_t         sh_q, sh_d;
    logic [31:0] res_q, res_d;
    logic        co_q, co_d;
    logic        rrx_q, rrx_d;

    logic [4:0]  k;
    logic [31:0] step_val;
    logic        step_cy;

    assign k = (rem_q > STEP_W) ? STEP_W[4:0] : rem_q[4:0];

    shift_step u_step (
        .value_i (val_q),
        .sh_i    (sh_q),
        .k_i     (k),
        .carry_i (cy_q),
        .value_o (step_val),
        .carry_o (step_cy)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cy_d    = cy_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        res_d   = res_q;
        co_d    = co_q;
        rrx_d   = rrx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d = data_in;
                    sh_d  = sh_t'(sh);
                    cy_d  = carry_in;
                    rrx_d = 1'b0;
                    case (sh_t'(sh))
                        LSL, LSR: rem_d = clamp_amt(amt, LSL_SAT);
                        ASR:      rem_d = clamp_amt(amt, ASR_SAT);
                        default: begin
                            rem_d = {1'b0, amt[4:0]};
                            // Multiple of 32: value unchanged, carry is bit 31.
                            if (amt != 8'd0 && amt[4:0] == 5'd0)
                                cy_d = data_in[31];
`ifdef SHIFT_CTRL_RRX_EN
                            if (amt == 8'd0) begin
                                rem_d = 6'd1;
                                rrx_d = 1'b1;
                            end
`endif
                        end
                    endcase
                    if (rem_d == 6'd0) begin
                        state_d = DONE;
                        res_d   = data_in;
                        co_d    = cy_d;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                val_d = step_val;
                cy_d  = step_cy;
`ifdef SHIFT_CTRL_RRX_EN
                if (rrx_q) begin
                    val_d = {cy_q, val_q[31:1]};
                    cy_d  = val_q[0];
                end
`endif
                rem_d = rem_q - {1'b0, k};
                if (rem_d == 6'd0) begin
                    state_d = DONE;
                    res_d   = val_d;
                    co_d    = cy_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            val_q   <= 32'b0;
            cy_q    <= 1'b0;
            rem_q   <= 6'b0;
            sh_q    <= LSL;
            res_q   <= 32'b0;
            co_q    <= 1'b0;
            rrx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cy_q    <= cy_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            co_q    <= co_d;
            rrx_q   <= rrx_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign carry_out = co_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: arithmetic reference model plus literal anchors.
module tb_shift_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [1:0]  sh;
    logic [7:0]  amt;
    logic        carry_in;
    logic        busy, done, carry_out;
    logic [31:0] result;

    shift_ctrl #(.STEP(16)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .sh(sh),
        .amt(amt), .carry_in(carry_in), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0;
    int ndone = 0;
    logic        pending = 1'b0;
    int          t_start = 0;
    logic [31:0] exp_res;
    logic        exp_co;
    int          exp_lat;

    localparam logic [31:0] D0 = 32'hFF1C10E7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference semantics straight from the shift rules, plus expected done latency.
    function automatic void model(input logic [31:0] d, input logic [1:0] s, input logic [7:0] a,
                                  input logic c, output logic [31:0] r, output logic co,
                                  output int lat);
        int ai, rem, ra;
        ai = int'(a);
        r = d; co = c; rem = 0;
        case (s)
            2'b00: begin
                rem = (ai > 33) ? 33 : ai;
                if (ai == 0) begin r = d; co = c; end
                else if (ai < 32) begin r = d << ai; co = d[32-ai]; end
                else if (ai == 32) begin r = 0; co = d[0]; end
                else begin r = 0; co = 1'b0; end
            end
            2'b01: begin
                rem = (ai > 33) ? 33 : ai;
                if (ai == 0) begin r = d; co = c; end
                else if (ai < 32) begin r = d >> ai; co = d[ai-1]; end
                else if (ai == 32) begin r = 0; co = d[31]; end
                else begin r = 0; co = 1'b0; end
            end
            2'b10: begin
                rem = (ai > 32) ? 32 : ai;
                if (ai == 0) begin r = d; co = c; end
                else if (ai >= 32) begin r = {32{d[31]}}; co = d[31]; end
                else begin r = $signed(d) >>> ai; co = d[ai-1]; end
            end
            default: begin
                ra = ai % 32;
                if (ai == 0) begin
`ifdef SHIFT_CTRL_RRX_EN
                    r = {c, d[31:1]}; co = d[0]; rem = 1;
`else
                    r = d; co = c; rem = 0;
`endif
                end else if (ra == 0) begin
                    r = d; co = d[31]; rem = 0;
                end else begin
                    r = (d >> ra) | (d << (32 - ra)); co = r[31]; rem = ra;
                end
            end
        endcase
        lat = (rem == 0) ? 1 : (rem + 15) / 16 + 1;
    endfunction

    // Per-cycle compare: busy window, done payload and done latency.
    always @(negedge clk) begin
        if (reset) begin
            chk("busy", {31'b0, busy}, {31'b0, pending && (cyc >= t_start)});
            if (done) begin
                ndone++;
                chk("done_expected", {31'b0, pending}, 32'd1);
                if (pending) begin
                    chk("result", result, exp_res);
                    chk("carry_out", {31'b0, carry_out}, {31'b0, exp_co});
                    chk("latency", cyc - t_start + 1, exp_lat);
                end
                pending = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [1:0] s, input logic [7:0] a,
                         input logic c);
        model(d, s, a, c, exp_res, exp_co, exp_lat);
        @(negedge clk);
        data_in = d; sh = s; amt = a; carry_in = c; start = 1'b1;
        t_start = cyc + 1;
        pending = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = ~d; sh = ~s; amt = 8'hFF; carry_in = ~c;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && pending; i++) @(negedge clk);
        if (pending) begin
            chk("timeout", {31'b0, pending}, 32'd0);
            pending = 1'b0;
        end
    endtask

    task automatic run(input logic [31:0] d, input logic [1:0] s, input logic [7:0] a,
                       input logic c);
        issue(d, s, a, c);
        wait_done();
    endtask

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        logic [7:0]  a;
        logic        c;
    } vec_t;

    vec_t vecs[12] = '{
        '{32'h80000001, 2'b00, 8'd1,   1'b0},
        '{32'h80000001, 2'b00, 8'd32,  1'b0},
        '{32'hFFFFFFFF, 2'b00, 8'd33,  1'b1},
        '{32'h12345678, 2'b01, 8'd16,  1'b0},
        '{32'h12345678, 2'b01, 8'd31,  1'b1},
        '{32'h7FFFFFFF, 2'b10, 8'd200, 1'b1},
        '{32'h80000000, 2'b10, 8'd255, 1'b0},
        '{32'h80000000, 2'b10, 8'd31,  1'b0},
        '{32'h12345678, 2'b11, 8'd16,  1'b0},
        '{32'h12345678, 2'b11, 8'd64,  1'b0},
        '{32'hA5A5A5A5, 2'b11, 8'd47,  1'b0},
        '{32'hC0000003, 2'b01, 8'd0,   1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        reset = 1'b0; start = 1'b0; data_in = '0; sh = '0; amt = '0; carry_in = 1'b0;
        #12;
        chk("reset_result", result, 32'd0);
        chk("reset_carry", {31'b0, carry_out}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk); reset = 1'b1;

        run(D0, 2'b00, 8'd17, 1'b0);
        chk("lsl17_lit", result, 32'h21CE0000);
        chk("lsl17_c_lit", {31'b0, carry_out}, 32'd0);
        run(D0, 2'b11, 8'd21, 1'b0);
        chk("ror21_lit", result, 32'hE0873FF8);
        chk("ror21_c_lit", {31'b0, carry_out}, 32'd1);
        run(D0, 2'b11, 8'd32, 1'b0);
        chk("ror32_lit", result, D0);
        chk("ror32_c_lit", {31'b0, carry_out}, 32'd1);
        run(D0, 2'b10, 8'd3, 1'b0);
        chk("asr3_lit", result, 32'hFFE3821C);
        chk("asr3_c_lit", {31'b0, carry_out}, 32'd1);
        run(D0, 2'b01, 8'd40, 1'b1);
        chk("lsr40_lit", result, 32'd0);
        chk("lsr40_lat_lit", exp_lat, 4);
        run(D0, 2'b01, 8'd32, 1'b0);
        chk("lsr32_c_lit", {31'b0, carry_out}, 32'd1);
        run(D0, 2'b00, 8'd0, 1'b1);
        chk("lsl0_lit", result, D0);
        chk("lsl0_c_lit", {31'b0, carry_out}, 32'd1);
        run(D0, 2'b11, 8'd0, 1'b1);
`ifdef SHIFT_CTRL_RRX_EN
        chk("rrx_lit", result, 32'hFF8E0873);
`else
        chk("ror0_lit", result, D0);
`endif
        chk("ror0_c_lit", {31'b0, carry_out}, 32'd1);

        foreach (vecs[i]) run(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].c);

        // Start while busy must be dropped, not queued.
        n0 = ndone;
        issue(D0, 2'b00, 8'd17, 1'b0);
        data_in = 32'h12345678; sh = 2'b01; amt = 8'd1; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        chk("ignored_start_result", result, 32'h21CE0000);
        chk("ignored_start_dones", ndone - n0, 1);

        // Asynchronous abort mid-SHIFT.
        issue(D0, 2'b01, 8'd40, 1'b0);
        @(negedge clk);
        #2;
        pending = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_carry", {31'b0, carry_out}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        run(32'h0000F00F, 2'b10, 8'd4, 1'b1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
